// File: rtl/risc_pkg.sv
// Shared opcode and phase encodings for the RISC-Y instruction sequencer.
package risc_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    // Instructions that read an operand from memory and write the accumulator.
    function automatic logic is_aluop(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/risc_controller.sv
// Eight-phase instruction sequencer: phase counter plus halt flag, with the
// control strobes decoded combinationally from the registered phase.
module risc_controller
    import risc_pkg::*;
#(
    parameter int unsigned OP_WIDTH = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [OP_WIDTH-1:0] OPCODE,
    input  logic                ZERO,
    output logic                SEL,
    output logic                RD,
    output logic                LD_IR,
    output logic                LD_AC,
    output logic                WR,
    output logic                DATA_E,
    output logic                PC_ENA,
    output logic                PC_LOAD,
    output logic                HALT,
    output logic [2:0]          PHASE
);

    phase_t  r_phase;
    logic    r_halted;
    opcode_t w_op;

    logic    w_sel, w_rd, w_ld_ir, w_ld_ac, w_wr, w_data_e;
    logic    w_inc, w_ldp, w_halt;

    assign w_op = opcode_t'(OPCODE);

    // Halt is taken at the phase-4 edge, so the PC still steps past the HLT.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_phase  <= INST_ADDR;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            if (r_phase == OP_ADDR && w_op == HLT) begin
                r_halted <= 1'b1;
            end else begin
                r_phase <= phase_t'(r_phase + 3'd1);
            end
        end
    end

    // OPCODE is only consulted from phase 4 on, keeping fetch-time X off the outputs.
    always_comb begin
        w_sel    = 1'b0;
        w_rd     = 1'b0;
        w_ld_ir  = 1'b0;
        w_ld_ac  = 1'b0;
        w_wr     = 1'b0;
        w_data_e = 1'b0;
        w_inc    = 1'b0;
        w_ldp    = 1'b0;
        w_halt   = 1'b0;
        if (!RST) begin
            w_halt = 1'b0;
        end else if (r_halted) begin
            w_halt = 1'b1;
        end else begin
            case (r_phase)
                INST_ADDR: begin
                    w_sel = 1'b1;
                end
                INST_FETCH: begin
                    w_sel = 1'b1;
                    w_rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    w_sel   = 1'b1;
                    w_rd    = 1'b1;
                    w_ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    w_inc  = 1'b1;
                    w_halt = (w_op == HLT);
                end
                OP_FETCH: begin
                    w_rd = is_aluop(w_op);
                end
                ALU_OP: begin
                    w_rd     = is_aluop(w_op);
                    w_inc    = (w_op == SKZ) && ZERO;
                    w_ldp    = (w_op == JMP);
                    w_data_e = (w_op == STO);
                end
                STORE: begin
                    w_rd     = is_aluop(w_op);
                    w_inc    = (w_op == JMP);
                    w_ldp    = (w_op == JMP);
                    w_ld_ac  = is_aluop(w_op);
                    w_wr     = (w_op == STO);
                    w_data_e = (w_op == STO);
                end
                default: begin
                    w_sel = 1'b0;
                end
            endcase
        end
    end

    assign SEL     = w_sel;
    assign RD      = w_rd;
    assign LD_IR   = w_ld_ir;
    assign LD_AC   = w_ld_ac;
    assign WR      = w_wr;
    assign DATA_E  = w_data_e;
    assign PC_ENA  = w_inc | w_ldp;
    assign PC_LOAD = w_ldp;
    assign HALT    = w_halt;
    assign PHASE   = RST ? 3'(r_phase) : 3'b000;

endmodule

// File: tb/tb_risc_controller.sv
// Directed cycle-by-cycle bench for the RISC-Y sequencer.
module tb_risc_controller;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [2:0] OPCODE = 3'd0;
    logic       ZERO = 1'b0;
    logic       SEL, RD, LD_IR, LD_AC, WR, DATA_E, PC_ENA, PC_LOAD, HALT;
    logic [2:0] PHASE;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    risc_controller #(.OP_WIDTH(3)) dut (
        .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .ZERO(ZERO),
        .SEL(SEL), .RD(RD), .LD_IR(LD_IR), .LD_AC(LD_AC), .WR(WR),
        .DATA_E(DATA_E), .PC_ENA(PC_ENA), .PC_LOAD(PC_LOAD), .HALT(HALT),
        .PHASE(PHASE)
    );

    // Expected strobe vector bit order: SEL RD LD_IR LD_AC WR DATA_E PC_ENA PC_LOAD HALT
    typedef struct {
        logic       rst;
        logic [2:0] op;
        logic       zero;
        logic [8:0] exp;
        logic [2:0] ph;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic push(input logic rst, input logic [2:0] op, input logic zero,
                        input logic [8:0] exp, input logic [2:0] ph, input string name);
        vec_t v;
        v.rst = rst; v.op = op; v.zero = zero; v.exp = exp; v.ph = ph; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic rst, input logic [2:0] op, input logic zero,
                         input logic [8:0] exp, input logic [2:0] ph, input string name);
        logic [8:0] act;
        @(negedge CLK);
        RST = rst; OPCODE = op; ZERO = zero;
        #1;
        act = {SEL, RD, LD_IR, LD_AC, WR, DATA_E, PC_ENA, PC_LOAD, HALT};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s strobes: got %b expected %b", name, act, exp);
        end
        checks++;
        if (PHASE !== ph) begin
            errors++;
            $display("FAIL %s PHASE: got %0d expected %0d", name, PHASE, ph);
        end
    endtask

    initial begin
        // Reset, then one instruction per opcode under test.
        push(0, 3'd5, 1, 9'b000000000, 0, "rst0");
        push(0, 3'd2, 1, 9'b000000000, 0, "rst1");
        // ADD, with junk opcodes in phases 0-2
        push(1, 3'd0, 0, 9'b100000000, 0, "add_p0");
        push(1, 3'd6, 1, 9'b110000000, 1, "add_p1");
        push(1, 3'd7, 0, 9'b111000000, 2, "add_p2");
        push(1, 3'd2, 0, 9'b111000000, 3, "add_p3");
        push(1, 3'd2, 0, 9'b000000100, 4, "add_p4");
        push(1, 3'd2, 0, 9'b010000000, 5, "add_p5");
        push(1, 3'd2, 1, 9'b010000000, 6, "add_p6");
        push(1, 3'd2, 0, 9'b010100000, 7, "add_p7");
        // STO
        push(1, 3'd0, 0, 9'b100000000, 0, "sto_p0");
        push(1, 3'd0, 0, 9'b110000000, 1, "sto_p1");
        push(1, 3'd0, 0, 9'b111000000, 2, "sto_p2");
        push(1, 3'd6, 0, 9'b111000000, 3, "sto_p3");
        push(1, 3'd6, 0, 9'b000000100, 4, "sto_p4");
        push(1, 3'd6, 0, 9'b000000000, 5, "sto_p5");
        push(1, 3'd6, 0, 9'b000001000, 6, "sto_p6");
        push(1, 3'd6, 0, 9'b000011000, 7, "sto_p7");
        // JMP
        push(1, 3'd7, 0, 9'b100000000, 0, "jmp_p0");
        push(1, 3'd7, 0, 9'b110000000, 1, "jmp_p1");
        push(1, 3'd7, 0, 9'b111000000, 2, "jmp_p2");
        push(1, 3'd7, 0, 9'b111000000, 3, "jmp_p3");
        push(1, 3'd7, 0, 9'b000000100, 4, "jmp_p4");
        push(1, 3'd7, 0, 9'b000000000, 5, "jmp_p5");
        push(1, 3'd7, 0, 9'b000000110, 6, "jmp_p6");
        push(1, 3'd7, 0, 9'b000000110, 7, "jmp_p7");
        // SKZ taken
        push(1, 3'd1, 1, 9'b100000000, 0, "skz1_p0");
        push(1, 3'd1, 1, 9'b110000000, 1, "skz1_p1");
        push(1, 3'd1, 1, 9'b111000000, 2, "skz1_p2");
        push(1, 3'd1, 1, 9'b111000000, 3, "skz1_p3");
        push(1, 3'd1, 1, 9'b000000100, 4, "skz1_p4");
        push(1, 3'd1, 1, 9'b000000000, 5, "skz1_p5");
        push(1, 3'd1, 1, 9'b000000100, 6, "skz1_p6");
        push(1, 3'd1, 1, 9'b000000000, 7, "skz1_p7");
        // SKZ not taken
        push(1, 3'd1, 0, 9'b100000000, 0, "skz0_p0");
        push(1, 3'd1, 0, 9'b110000000, 1, "skz0_p1");
        push(1, 3'd1, 0, 9'b111000000, 2, "skz0_p2");
        push(1, 3'd1, 0, 9'b111000000, 3, "skz0_p3");
        push(1, 3'd1, 0, 9'b000000100, 4, "skz0_p4");
        push(1, 3'd1, 0, 9'b000000000, 5, "skz0_p5");
        push(1, 3'd1, 0, 9'b000000000, 6, "skz0_p6");
        push(1, 3'd1, 0, 9'b000000000, 7, "skz0_p7");
        // XOR: ALU op with ZERO set in phase 6 must not bump the PC
        push(1, 3'd4, 1, 9'b100000000, 0, "xor_p0");
        push(1, 3'd4, 1, 9'b110000000, 1, "xor_p1");
        push(1, 3'd4, 1, 9'b111000000, 2, "xor_p2");
        push(1, 3'd4, 1, 9'b111000000, 3, "xor_p3");
        push(1, 3'd4, 1, 9'b000000100, 4, "xor_p4");
        push(1, 3'd4, 1, 9'b010000000, 5, "xor_p5");
        push(1, 3'd4, 1, 9'b010000000, 6, "xor_p6");
        push(1, 3'd4, 1, 9'b010100000, 7, "xor_p7");

        RST = 1'b0;
        foreach (vecs[i])
            apply(vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].exp, vecs[i].ph, vecs[i].name);

        // HLT: PC steps once in phase 4, then everything freezes.
        apply(1, 3'd0, 0, 9'b100000000, 0, "hlt_p0");
        apply(1, 3'd0, 0, 9'b110000000, 1, "hlt_p1");
        apply(1, 3'd0, 0, 9'b111000000, 2, "hlt_p2");
        apply(1, 3'd0, 0, 9'b111000000, 3, "hlt_p3");
        apply(1, 3'd0, 0, 9'b000000101, 4, "hlt_p4");
        for (int k = 0; k < 20; k++)
            apply(1, (k % 2 == 0) ? 3'd2 : 3'd7, k[0], 9'b000000001, 4, "halted");
        apply(0, 3'd0, 0, 9'b000000000, 0, "hlt_rst");
        apply(1, 3'd6, 0, 9'b100000000, 0, "post_hlt_p0");

        // STO interrupted by reset in phase 6: WR must never appear.
        apply(1, 3'd6, 0, 9'b110000000, 1, "stor_p1");
        apply(1, 3'd6, 0, 9'b111000000, 2, "stor_p2");
        apply(1, 3'd6, 0, 9'b111000000, 3, "stor_p3");
        apply(1, 3'd6, 0, 9'b000000100, 4, "stor_p4");
        apply(1, 3'd6, 0, 9'b000000000, 5, "stor_p5");
        apply(0, 3'd6, 0, 9'b000000000, 0, "stor_rst_p6");
        apply(1, 3'd6, 0, 9'b100000000, 0, "stor_after_p0");
        apply(1, 3'd2, 0, 9'b110000000, 1, "stor_after_p1");
        apply(1, 3'd2, 0, 9'b111000000, 2, "stor_after_p2");
        apply(1, 3'd2, 0, 9'b111000000, 3, "stor_after_p3");
        apply(1, 3'd2, 0, 9'b000000100, 4, "stor_after_p4");
        apply(1, 3'd2, 0, 9'b010000000, 5, "stor_after_p5");
        apply(1, 3'd2, 0, 9'b010000000, 6, "stor_after_p6");
        apply(1, 3'd2, 0, 9'b010100000, 7, "stor_after_p7");
        apply(1, 3'd2, 0, 9'b100000000, 0, "wrap_p0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/risc_controller.md
Name: risc_controller

Overview:
- Eight-phase instruction sequencer for the RISC-Y core.
- Sits directly upstream of the program counter and drives its PC_ENA/PC_LOAD strobes. Also drives the memory, IR, accumulator and address-mux control lines.
- One instruction takes 8 clocks. The opcode comes from the instruction register; the accumulator-zero flag comes from the ALU.

Parameters:
OP_WIDTH, 3, opcode width; only the value 3 is supported.

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous active-low reset
OPCODE  input  OP_WIDTH  opcode from IR; valid from phase 3 onward
ZERO  input  1  accumulator == 0 flag
SEL  output  1  address mux select: 1=PC, 0=IR operand
RD  output  1  memory read enable
LD_IR  output  1  instruction register load
LD_AC  output  1  accumulator load
WR  output  1  memory write strobe
DATA_E  output  1  accumulator drives data bus
PC_ENA  output  1  program counter enable
PC_LOAD  output  1  program counter load (1=load DATA, 0=increment)
HALT  output  1  processor halted
PHASE  output  3  current phase, debug

Behaviour:
- Clocking and reset:
  - Single clock; all state changes on rising CLK.
  - RST is sampled only at the edge. RST=0 at an edge sets phase=INST_ADDR(0) and halted=0.
  - While RST=0, all outputs are forced 0, including PHASE=0.
  - Reset mid-instruction abandons that instruction. No partial write completes after the reset edge.
- Phase register:
  - 3-bit, advances 0->1->...->7->0 every clock unless halted.
  - Wraps 7->0 unconditionally.
- Opcodes:
  - HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
  - ALUOP = ADD|AND|XOR|LDA.
- Outputs are combinational decode of registered phase, OPCODE and ZERO, with no added latency. Unlisted outputs are 0.
  - phase 0 INST_ADDR: SEL=1.
  - phase 1 INST_FETCH: SEL=1, RD=1.
  - phase 2 INST_LOAD: SEL=1, RD=1, LD_IR=1.
  - phase 3 IDLE: SEL=1, RD=1, LD_IR=1.
  - phase 4 OP_ADDR: INC=1, HALT=(OPCODE==HLT).
  - phase 5 OP_FETCH: RD=ALUOP.
  - phase 6 ALU_OP: RD=ALUOP; INC=(SKZ & ZERO); LDP=JMP; DATA_E=STO.
  - phase 7 STORE: RD=ALUOP; INC=JMP; LDP=JMP; LD_AC=ALUOP; WR=STO; DATA_E=STO.
- PC interface mapping: PC_ENA = INC | LDP; PC_LOAD = LDP. In phase 7 JMP, load wins over increment.
- Halt:
  - At the phase-4 edge with OPCODE==HLT, halted is set and phase freezes at 4.
  - While halted: HALT=1 and all other outputs 0 (PC_ENA=0, so the PC holds). PHASE reads 4.
  - Only reset clears halted.
  - The PC increments once in the first HLT phase-4 cycle, before halted is set. This is required behaviour: the PC points past the HLT.
- Boundaries:
  - OPCODE changes outside phases 3-7 have no effect on SEL/RD/LD_IR.
  - ZERO is used only in phase 6 and only for SKZ.
  - X on OPCODE during phases 0-2 must not propagate to outputs.

Decomposition:
- Package risc_pkg:
  - opcode_t enum (3-bit, values above).
  - phase_t enum (INST_ADDR..STORE, 3-bit).
  - ALUOP helper function is_aluop(opcode_t).
- Single module with no sub-module. Phase register, halted flag and decode fit in one always_ff and one always_comb.

Test Plan:
- RST=0 for 2 clocks, then release -> all outputs 0 during reset; PHASE steps 0,1,2,...,7,0; SEL=1 exactly in phases 0-3.
- OPCODE=ADD(2) -> RD=1 in phases 1,2,3,5,6,7; LD_IR=1 in phases 2,3; LD_AC=1 only in phase 7; PC_ENA=1, PC_LOAD=0 only in phase 4.
- OPCODE=STO(6) -> DATA_E=1 in phases 6,7; WR=1 only in phase 7; RD=0 in phases 5-7.
- OPCODE=JMP(7) -> PC_ENA=1/PC_LOAD=1 in phases 6 and 7; PC_ENA=1/PC_LOAD=0 in phase 4.
- OPCODE=SKZ(1) with ZERO=1 -> PC_ENA=1 in phases 4 and 6 (2 increments). With ZERO=0 -> PC_ENA=1 in phase 4 only.
- OPCODE=HLT(0) -> HALT=1 from phase 4 onward; PHASE stuck at 4 for 20 clocks with PC_ENA=0. Then RST=0 for 1 clock -> HALT=0, PHASE=0 on release. Also assert RST=0 in phase 6 of a STO -> WR never asserts.
